// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one ALU and one register file sequenced by an FSM,
// with instruction and data traffic sharing a word-addressed req/ready memory port.
module multi_cycle_cpu #(
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        reg_addr,
  output logic [31:0]       reg_data,
  output logic [ADDR_W-1:0] PC,
  output logic [31:0]       instr,
  output logic [2:0]        state,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd5
  } state_e;

  typedef enum logic [2:0] {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_BAD} op_e;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_alu_out;
  logic [31:0]       r_mdr;
  logic              r_illegal;
  logic [31:0]       r_gpr [32];

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [31:0]       w_sext_imm;
  op_e               w_op;
  logic [31:0]       w_alu_r;
  logic [31:0]       w_addr_sum;
  logic [ADDR_W-1:0] w_br_target;
  logic [4:0]        w_wb_idx;
  logic [31:0]       w_wb_data;
  logic              w_wb_en;

  assign w_opcode    = r_ir[31:26];
  assign w_rs        = r_ir[25:21];
  assign w_rt        = r_ir[20:16];
  assign w_rd        = r_ir[15:11];
  assign w_funct     = r_ir[5:0];
  assign w_sext_imm  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_addr_sum  = r_a + w_sext_imm;
  assign w_br_target = r_pc + w_sext_imm[ADDR_W-1:0];

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it
  // unassigned; a missed branch would otherwise infer a latch.
  always_comb begin
    w_op = OP_BAD;
    case (w_opcode)
      OPC_R:    if (w_funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT}) w_op = OP_R;
      OPC_ADDI: w_op = OP_ADDI;
      OPC_LW:   w_op = OP_LW;
      OPC_SW:   w_op = OP_SW;
      OPC_BEQ:  w_op = OP_BEQ;
      OPC_J:    w_op = OP_J;
      default:  w_op = OP_BAD;
    endcase
  end

  always_comb begin
    w_alu_r = r_a + r_b;
    case (w_funct)
      F_SUB:   w_alu_r = r_a - r_b;
      F_AND:   w_alu_r = r_a & r_b;
      F_OR:    w_alu_r = r_a | r_b;
      F_SLT:   w_alu_r = {31'b0, $signed(r_a) < $signed(r_b)};
      default: ;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IF;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IF:  if (mem_ready) w_state_next = S_ID;
      S_ID:  w_state_next = (w_op == OP_BAD) ? S_ERR : S_EX;
      S_EX: begin
        case (w_op)
          OP_R, OP_ADDI: w_state_next = S_WB;
          OP_LW, OP_SW:  w_state_next = S_MEM;
          default:       w_state_next = S_IF;
        endcase
      end
      S_MEM: if (mem_ready) w_state_next = (w_op == OP_LW) ? S_WB : S_IF;
      S_WB:  w_state_next = S_IF;
      S_ERR: w_state_next = S_ERR;
      default: w_state_next = S_IF;
    endcase
  end

  // The reset gate drops the request in the same cycle reset asserts, aborting any access.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_pc;
    mem_wdata = r_b;
    case (r_state)
      S_IF:  mem_req = 1'b1;
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = (w_op == OP_SW);
        mem_addr = r_alu_out[ADDR_W-1:0];
      end
      default: ;
    endcase
    if (!rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IF: begin
          if (mem_ready) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + ADDR_W'(1);
          end
        end
        S_ID: begin
          r_a       <= r_gpr[w_rs];
          r_b       <= r_gpr[w_rt];
          r_alu_out <= 32'(w_br_target);
          if (w_op == OP_BAD) r_illegal <= 1'b1;
        end
        S_EX: begin
          case (w_op)
            OP_R:                 r_alu_out <= w_alu_r;
            OP_ADDI, OP_LW, OP_SW: r_alu_out <= w_addr_sum;
            OP_BEQ:               if (r_a == r_b) r_pc <= r_alu_out[ADDR_W-1:0];
            OP_J:                 r_pc <= r_ir[ADDR_W-1:0];
            default: ;
          endcase
        end
        S_MEM: if (mem_ready && w_op == OP_LW) r_mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign w_wb_idx  = (w_op == OP_R) ? w_rd : w_rt;
  assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_alu_out;
  assign w_wb_en   = (r_state == S_WB) && (w_wb_idx != 5'd0);

  // NOTE: the register file must clear on reset, so it is built from flops with a reset
  // loop rather than a RAM macro (RAMs cannot be reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
    end else if (w_wb_en) begin
      r_gpr[w_wb_idx] <= w_wb_data;
    end
  end

  assign reg_data = r_gpr[reg_addr];
  assign PC       = r_pc;
  assign instr    = r_ir;
  assign state    = r_state;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Bench for multi_cycle_cpu: wait-state memory model, table of small programs with
// expected end state, store scoreboard, and hand-written reset/stall/error sequences.
module tb_multi_cycle_cpu;

  localparam int ADDR_W    = 9;
  localparam int MEM_WORDS = 1 << ADDR_W;

  localparam logic [2:0] ST_IF  = 3'd0;
  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB  = 3'd4;
  localparam logic [2:0] ST_ERR = 3'd5;

  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] F_ADD    = 6'b100000;
  localparam logic [5:0] F_SUB    = 6'b100010;
  localparam logic [5:0] F_AND    = 6'b100100;
  localparam logic [5:0] F_OR     = 6'b100101;
  localparam logic [5:0] F_SLT    = 6'b101010;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;
  logic [4:0]        reg_addr = 5'd0;
  logic [31:0]       reg_data;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr;
  logic [2:0]        dut_state;
  logic              illegal;

  multi_cycle_cpu #(.ADDR_W(ADDR_W), .RESET_PC(9'd0)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .reg_addr(reg_addr), .reg_data(reg_data),
    .PC(pc), .instr(instr), .state(dut_state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Memory model: program image from the bench, stores kept in an overlay written here.
  logic [31:0]       prog_mem    [MEM_WORDS];
  logic              store_valid [MEM_WORDS];
  logic [31:0]       store_data  [MEM_WORDS];
  int                wait_cfg = 0;
  int                wait_cnt;
  int                stall_cycles;
  int                stall_viol;
  logic              prev_stall;
  logic [ADDR_W-1:0] held_addr;
  logic              held_we;
  logic [31:0]       held_wdata;
  int                obs_cnt;
  logic [ADDR_W-1:0] obs_addr [8];
  logic [31:0]       obs_data [8];

  assign mem_ready = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata = store_valid[mem_addr] ? store_data[mem_addr] : prog_mem[mem_addr];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt     <= 0;
      stall_cycles <= 0;
      stall_viol   <= 0;
      prev_stall   <= 1'b0;
      obs_cnt      <= 0;
      for (int i = 0; i < MEM_WORDS; i++) store_valid[i] <= 1'b0;
    end else begin
      if (prev_stall && mem_req &&
          (mem_addr !== held_addr || mem_we !== held_we || (mem_we && mem_wdata !== held_wdata)))
        stall_viol <= stall_viol + 1;
      if (mem_req && !mem_ready) begin
        wait_cnt     <= wait_cnt + 1;
        stall_cycles <= stall_cycles + 1;
        prev_stall   <= 1'b1;
        held_addr    <= mem_addr;
        held_we      <= mem_we;
        held_wdata   <= mem_wdata;
      end else begin
        wait_cnt   <= 0;
        prev_stall <= 1'b0;
      end
      if (mem_req && mem_ready && mem_we) begin
        store_valid[mem_addr] <= 1'b1;
        store_data[mem_addr]  <= mem_wdata;
        if (obs_cnt < 8) begin
          obs_addr[obs_cnt] <= mem_addr;
          obs_data[obs_cnt] <= mem_wdata;
        end
        obs_cnt <= obs_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t exp_q [$];

  typedef struct {
    string             name;
    int                n;
    logic [ADDR_W-1:0] addr [6];
    logic [31:0]       data [6];
    int                wait_n;
    int                cycles;
    logic [4:0]        reg_idx;
    logic [31:0]       exp_reg;
    logic [ADDR_W-1:0] exp_pc;
    logic [2:0]        exp_state;
    logic              exp_ill;
    int                exp_stall;
    logic              has_store;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
  } vec_t;
  vec_t vecs [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] enc_j(logic [25:0] tgt);
    return {6'b000010, tgt};
  endfunction

  function automatic vec_t mk(string name, int cycles, int wait_n, logic [4:0] r,
                              logic [31:0] er, logic [ADDR_W-1:0] epc, logic [2:0] est,
                              logic eill, int estall);
    vec_t v;
    v.name = name;   v.n = 0;            v.wait_n = wait_n;  v.cycles = cycles;
    v.reg_idx = r;   v.exp_reg = er;     v.exp_pc = epc;     v.exp_state = est;
    v.exp_ill = eill; v.exp_stall = estall;
    v.has_store = 1'b0; v.st_addr = '0;  v.st_data = '0;
    for (int i = 0; i < 6; i++) begin
      v.addr[i] = '0;
      v.data[i] = '0;
    end
    return v;
  endfunction

  function automatic vec_t put(vec_t v, logic [ADDR_W-1:0] a, logic [31:0] d);
    v.addr[v.n] = a;
    v.data[v.n] = d;
    v.n++;
    return v;
  endfunction

  task automatic start(input int wait_n);
    rst      = 1'b0;
    wait_cfg = wait_n;
    exp_q.delete();
    for (int i = 0; i < MEM_WORDS; i++) prog_mem[i] = '0;
    @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic run_vector(input vec_t v);
    wr_t e;
    start(v.wait_n);
    for (int i = 0; i < v.n; i++) prog_mem[v.addr[i]] = v.data[i];
    if (v.has_store) begin
      e.addr = v.st_addr;
      e.data = v.st_data;
      exp_q.push_back(e);
    end
    reg_addr = v.reg_idx;
    release_rst();
    repeat (v.cycles) @(posedge clk);
    #1;
    check({v.name, "/reg"},     reg_data,      v.exp_reg);
    check({v.name, "/pc"},      32'(pc),       32'(v.exp_pc));
    check({v.name, "/state"},   32'(dut_state), 32'(v.exp_state));
    check({v.name, "/illegal"}, 32'(illegal),  32'(v.exp_ill));
    check({v.name, "/stalls"},  stall_cycles,  v.exp_stall);
    check({v.name, "/stable"},  stall_viol,    0);
    check({v.name, "/n_store"}, obs_cnt,       exp_q.size());
    for (int i = 0; i < obs_cnt && i < 8; i++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({v.name, "/st_addr"}, 32'(obs_addr[i]), 32'(e.addr));
        check({v.name, "/st_data"}, obs_data[i], e.data);
      end
    end
  endtask

  initial begin
    vec_t v;
    logic found;
    int   bad;

    v = mk("addi", 4, 0, 5'd1, 32'd5, 9'd1, ST_IF, 1'b0, 0);
    v = put(v, 9'd0, enc_i(OPC_ADDI, 5'd0, 5'd1, 16'd5));
    vecs.push_back(v);

    v = mk("slt", 16, 0, 5'd3, 32'd1, 9'd4, ST_IF, 1'b0, 0);
    v = put(v, 9'd0, enc_i(OPC_ADDI, 5'd0, 5'd1, 16'hFFFD));
    v = put(v, 9'd1, enc_i(OPC_ADDI, 5'd0, 5'd2, 16'd7));
    v = put(v, 9'd2, enc_r(5'd1, 5'd2, 5'd3, F_SLT));
    v = put(v, 9'd3, enc_r(5'd1, 5'd2, 5'd4, F_SUB));
    vecs.push_back(v);
    v.name = "sub"; v.reg_idx = 5'd4; v.exp_reg = 32'hFFFF_FFF6;
    vecs.push_back(v);

    v = mk("and", 12, 0, 5'd3, 32'd8, 9'd3, ST_IF, 1'b0, 0);
    v = put(v, 9'd0, enc_i(OPC_ADDI, 5'd0, 5'd1, 16'd12));
    v = put(v, 9'd1, enc_i(OPC_ADDI, 5'd0, 5'd2, 16'd10));
    v = put(v, 9'd2, enc_r(5'd1, 5'd2, 5'd3, F_AND));
    v = put(v, 9'd3, enc_r(5'd1, 5'd2, 5'd4, F_OR));
    v = put(v, 9'd4, enc_r(5'd1, 5'd2, 5'd5, F_ADD));
    vecs.push_back(v);
    v.name = "or";  v.cycles = 16; v.reg_idx = 5'd4; v.exp_reg = 32'd14; v.exp_pc = 9'd4;
    vecs.push_back(v);
    v.name = "add"; v.cycles = 20; v.reg_idx = 5'd5; v.exp_reg = 32'd22; v.exp_pc = 9'd5;
    vecs.push_back(v);

    v = mk("slt_false", 12, 0, 5'd1, 32'd0, 9'd3, ST_IF, 1'b0, 0);
    v = put(v, 9'd0, enc_i(OPC_ADDI, 5'd0, 5'd1, 16'hFFFD));
    v = put(v, 9'd1, enc_i(OPC_ADDI, 5'd0, 5'd2, 16'd7));
    v = put(v, 9'd2, enc_r(5'd2, 5'd1, 5'd1, F_SLT));
    vecs.push_back(v);

    // Three wait cycles on each of five accesses: 13 zero-wait cycles + 15.
    v = mk("sw_lw_wait3", 28, 3, 5'd5, 32'd7, 9'd3, ST_IF, 1'b0, 15);
    v = put(v, 9'd0, enc_i(OPC_ADDI, 5'd0, 5'd2, 16'd7));
    v = put(v, 9'd1, enc_i(OPC_SW,   5'd0, 5'd2, 16'd4));
    v = put(v, 9'd2, enc_i(OPC_LW,   5'd0, 5'd5, 16'd4));
    v.has_store = 1'b1; v.st_addr = 9'd4; v.st_data = 32'd7;
    vecs.push_back(v);
    v.name = "sw_lw_zero"; v.wait_n = 0; v.cycles = 13; v.exp_stall = 0;
    vecs.push_back(v);

    v = mk("lw_wait1", 7, 1, 5'd7, 32'hDEAD_BEEF, 9'd1, ST_IF, 1'b0, 2);
    v = put(v, 9'd0,  enc_i(OPC_LW, 5'd0, 5'd7, 16'd20));
    v = put(v, 9'd20, 32'hDEAD_BEEF);
    vecs.push_back(v);

    v = mk("beq_taken", 6, 0, 5'd1, 32'd0, 9'd10, ST_IF, 1'b0, 0);
    v = put(v, 9'd0,  enc_j(26'd10));
    v = put(v, 9'd10, enc_i(OPC_BEQ, 5'd1, 5'd1, 16'hFFFF));
    vecs.push_back(v);

    v = mk("beq_not_taken", 10, 0, 5'd1, 32'd1, 9'd11, ST_IF, 1'b0, 0);
    v = put(v, 9'd0,  enc_i(OPC_ADDI, 5'd0, 5'd1, 16'd1));
    v = put(v, 9'd1,  enc_j(26'd10));
    v = put(v, 9'd10, enc_i(OPC_BEQ, 5'd1, 5'd0, 16'd5));
    vecs.push_back(v);

    v = mk("j_top", 3, 0, 5'd6, 32'd0, 9'h1FF, ST_IF, 1'b0, 0);
    v = put(v, 9'd0,   enc_j(26'h1FF));
    v = put(v, 9'h1FF, enc_i(OPC_ADDI, 5'd0, 5'd6, 16'd2));
    vecs.push_back(v);
    v.name = "j_wrap"; v.cycles = 7; v.exp_reg = 32'd2; v.exp_pc = 9'd0;
    vecs.push_back(v);

    v = mk("illegal", 10, 0, 5'd0, 32'd0, 9'd1, ST_ERR, 1'b1, 0);
    v = put(v, 9'd0, 32'hFC00_0000);
    vecs.push_back(v);

    v = mk("write_r0", 4, 0, 5'd0, 32'd0, 9'd1, ST_IF, 1'b0, 0);
    v = put(v, 9'd0, enc_i(OPC_ADDI, 5'd0, 5'd0, 16'd9));
    vecs.push_back(v);

    foreach (vecs[i]) run_vector(vecs[i]);

    // Reset release, first fetch, and WB debug-read timing.
    start(0);
    prog_mem[0] = enc_i(OPC_ADDI, 5'd0, 5'd1, 16'd5);
    reg_addr = 5'd1;
    check("rst/mem_req", 32'(mem_req), 32'd0);
    release_rst();
    check("c1/mem_req",  32'(mem_req),  32'd1);
    check("c1/mem_addr", 32'(mem_addr), 32'd0);
    check("c1/mem_we",   32'(mem_we),   32'd0);
    @(posedge clk); #1;
    check("id/state",   32'(dut_state), 32'(ST_ID));
    check("id/mem_req", 32'(mem_req),   32'd0);
    check("id/instr",   instr,          enc_i(OPC_ADDI, 5'd0, 5'd1, 16'd5));
    check("id/pc",      32'(pc),        32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("wb/state",    32'(dut_state), 32'(ST_WB));
    check("wb/old_data", reg_data,       32'd0);
    @(posedge clk); #1;
    check("wb/new_data", reg_data, 32'd5);

    // Reset asserted while a store waits in MEM.
    start(3);
    prog_mem[0] = enc_i(OPC_ADDI, 5'd0, 5'd2, 16'd7);
    prog_mem[1] = enc_i(OPC_SW,   5'd0, 5'd2, 16'd4);
    reg_addr = 5'd2;
    release_rst();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (dut_state == ST_MEM) found = 1'b1;
    end
    check("midmem/reached", 32'(found), 32'd1);
    check("midmem/req",   32'(mem_req),  32'd1);
    check("midmem/we",    32'(mem_we),   32'd1);
    check("midmem/addr",  32'(mem_addr), 32'd4);
    check("midmem/wdata", mem_wdata,     32'd7);
    check("midmem/r2",    reg_data,      32'd7);
    rst = 1'b0;
    #1;
    check("midrst/req",   32'(mem_req),   32'd0);
    check("midrst/state", 32'(dut_state), 32'(ST_IF));
    check("midrst/pc",    32'(pc),        32'd0);
    check("midrst/r2",    reg_data,       32'd0);
    check("midrst/instr", instr,          32'd0);

    // Illegal opcode parks the core in ERR until reset.
    start(0);
    prog_mem[0] = 32'hFC00_0000;
    release_rst();
    repeat (2) @(posedge clk);
    #1;
    check("err/state",   32'(dut_state), 32'(ST_ERR));
    check("err/illegal", 32'(illegal),   32'd1);
    check("err/mem_req", 32'(mem_req),   32'd0);
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || dut_state !== ST_ERR || illegal !== 1'b1 || pc !== 9'd1) bad++;
    end
    check("err/hold", bad, 0);
    rst = 1'b0;
    #1;
    check("err_rst/illegal", 32'(illegal),   32'd0);
    check("err_rst/pc",      32'(pc),        32'd0);
    check("err_rst/state",   32'(dut_state), 32'(ST_IF));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
